divider_arbiter: RTL and testbench

- Shares one iterative 64/32 divider between N_REQ requesters.
- Performs round-robin arbitration, latches the winner's operands and pulses the divider start.
- Waits for divider done, then returns the quotient tagged with the requester id.
- Short-circuits divide-by-zero and guards against a hung divider with a timeout.

---
 rtl/divider_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_divider_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// ----------------------------------------------------------------------------
// divider_arbiter
//   Shares one iterative 64/32 divider between N_REQ requesters. A round-robin
//   arbiter picks a requester in IDLE, its operands are latched, and the
//   divider is started. The divider's quotient is returned tagged with the
//   requester id. A zero denominator is answered directly without using the
//   divider. A divider that never signals done is cut off by a timeout.
//
// Ports
//   clk, rstn          : clock (rising edge), synchronous active-low reset
//   req_valid/ready    : per-requester request handshake (ready one-hot/zero)
//   req_numerator      : packed 64-bit numerators, requester i at [64*i +: 64]
//   req_denominator    : packed 32-bit denominators, requester i at [32*i +: 32]
//   rsp_valid/ready    : response handshake
//   rsp_id             : requester that owns the response
//   rsp_quotient       : quotient (all ones on divide-by-zero, 0 on timeout)
//   rsp_div_zero       : denominator was zero
//   rsp_timeout        : divider did not finish within TIMEOUT_CYC cycles
//   div_start          : one-cycle start pulse to the divider
//   div_numerator      : latched numerator, stable from ISSUE through WAIT
//   div_denominator    : latched denominator, stable from ISSUE through WAIT
//   div_done           : divider completion pulse (only honoured in WAIT)
//   div_quotient       : divider result, valid with div_done
//   busy               : high whenever the FSM is not in IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The requester side has ready asserted combinationally in IDLE;
// the response side holds valid and its payload stable until ready.
// ----------------------------------------------------------------------------
module divider_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int TIMEOUT_CYC = 64,
    localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [64*N_REQ-1:0]   req_numerator,
    input  logic [32*N_REQ-1:0]   req_denominator,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_quotient,
    output logic                  rsp_div_zero,
    output logic                  rsp_timeout,
    output logic                  div_start,
    output logic [63:0]           div_numerator,
    output logic [31:0]           div_denominator,
    input  logic                  div_done,
    input  logic [31:0]           div_quotient,
    output logic                  busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]   id_q,       id_d;
    logic [TMR_W-1:0]  timer_q,    timer_d;
    logic [63:0]       num_q,      num_d;
    logic [31:0]       den_q,      den_d;
    logic [31:0]       quot_q,     quot_d;
    logic              div_zero_q, div_zero_d;
    logic              timeout_q,  timeout_d;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [63:0]       sel_num;
    logic [31:0]       sel_den;

    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        sel_num   = '0;
        sel_den   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
                sel_num   = req_numerator[64*idx +: 64];
                sel_den   = req_denominator[32*idx +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        timer_d    = timer_q;
        num_d      = num_q;
        den_d      = den_q;
        quot_d     = quot_q;
        div_zero_d = div_zero_q;
        timeout_d  = timeout_q;
        req_ready  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    // Gated by rstn so nothing is acknowledged while in reset.
                    req_ready[grant_idx] = rstn;
                    num_d     = sel_num;
                    den_d     = sel_den;
                    id_d      = grant_idx;
                    timeout_d = 1'b0;
                    if (sel_den == 32'd0) begin
                        quot_d     = '1;
                        div_zero_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        quot_d     = '0;
                        div_zero_d = 1'b0;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    quot_d     = div_quotient;
                    div_zero_d = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    quot_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    // Next search starts just after the requester just served.
                    rr_ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    quot_d     = '0;
                    div_zero_d = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            timer_q    <= '0;
            num_q      <= '0;
            den_q      <= '0;
            quot_q     <= '0;
            div_zero_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            timer_q    <= timer_d;
            num_q      <= num_d;
            den_q      <= den_d;
            quot_q     <= quot_d;
            div_zero_q <= div_zero_d;
            timeout_q  <= timeout_d;
        end
    end

    // All of these decode registered state only.
    assign rsp_valid       = (state_q == S_RESP);
    assign busy            = (state_q != S_IDLE);
    assign div_start       = (state_q == S_ISSUE);
    assign rsp_id          = id_q;
    assign rsp_quotient    = quot_q;
    assign rsp_div_zero    = div_zero_q;
    assign rsp_timeout     = timeout_q;
    assign div_numerator   = num_q;
    assign div_denominator = den_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// ----------------------------------------------------------------------------
// tb_divider_arbiter
//   Directed bench for divider_arbiter with a behavioural iterative divider
//   that raises div_done model_lat cycles after the start cycle (or never,
//   when model_hang is set). Each scenario task drives stimulus and checks
//   hand-computed expected values inline.
// ----------------------------------------------------------------------------
module tb_divider_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [64*N-1:0]   req_numerator;
  logic [32*N-1:0]   req_denominator;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_quotient;
  logic              rsp_div_zero;
  logic              rsp_timeout;
  logic              div_start;
  logic [63:0]       div_numerator;
  logic [31:0]       div_denominator;
  logic              div_done;
  logic [31:0]       div_quotient;
  logic              busy;

  int passed = 0;
  int total  = 0;

  divider_arbiter #(.N_REQ(N), .TIMEOUT_CYC(64)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_numerator   (req_numerator),
    .req_denominator (req_denominator),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_quotient    (rsp_quotient),
    .rsp_div_zero    (rsp_div_zero),
    .rsp_timeout     (rsp_timeout),
    .div_start       (div_start),
    .div_numerator   (div_numerator),
    .div_denominator (div_denominator),
    .div_done        (div_done),
    .div_quotient    (div_quotient),
    .busy            (busy)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  // ---------------- divider model ----------------
  int          model_lat  = 4;
  bit          model_hang = 1'b0;
  int          model_cnt  = -1;
  logic [31:0] model_quot = '0;

  initial begin
    div_done     = 1'b0;
    div_quotient = '0;
  end

  always @(negedge clk) begin
    div_done = 1'b0;
    if (div_start) begin
      model_cnt  = model_hang ? -1 : model_lat;
      model_quot = 32'(div_numerator / {32'd0, div_denominator});
    end else if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) begin
        div_done     = 1'b1;
        div_quotient = model_quot;
        model_cnt    = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [63:0] num, input logic [31:0] den);
    req_numerator[64*id +: 64]   = num;
    req_denominator[32*id +: 32] = den;
  endtask

  task automatic apply_reset;
    tick;
    rstn = 1'b0;
    tick;
    tick;
    rstn = 1'b1;
  endtask

  // Waits for rsp_valid; n = cycles waited, -1 when the bound expires.
  task automatic wait_rsp(output int n);
    n = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = c;
        break;
      end
    end
  endtask

  // Presents one request, captures req_ready in the grant cycle, drops the
  // request after the handshake edge, and waits for the response.
  task automatic drive_txn(input int id, input logic [63:0] num, input logic [31:0] den,
                           output logic [N-1:0] rdy_seen, output int lat,
                           output int starts, output bit busy_low);
    tick;
    set_req(id, num, den);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    @(negedge clk);
    rdy_seen = req_ready;
    lat      = -1;
    starts   = 0;
    busy_low = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = '0;
      if (div_start) starts++;
      if (!busy) busy_low = 1'b1;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) $display("FAIL %s_drain: DUT still busy after 500 cycles, expected idle", name);
    else passed++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rstn      = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_div_zero, rsp_timeout,
         div_start, div_numerator, div_denominator, busy} !== '0)
      $display("FAIL reset_outputs: rdy=%b vld=%b id=%0d q=%h dz=%b to=%b st=%b num=%h den=%h busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_div_zero, rsp_timeout,
               div_start, div_numerator, div_denominator, busy);
    else passed++;
    tick;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b, expected 0", busy);
    else passed++;
  endtask

  task automatic test_single;
    logic [N-1:0] rdy;
    int lat, starts;
    bit busy_low;
    bit num_ok;
    model_lat = 18;
    rsp_ready = 1'b0;
    drive_txn(2, 64'd100, 32'd7, rdy, lat, starts, busy_low);
    total++;
    if (rdy !== 4'b0100) $display("FAIL single_ready: got %b, expected 0100", rdy);
    else passed++;
    total++;
    if (lat !== 20) $display("FAIL single_latency: got %0d, expected 20", lat);
    else passed++;
    total++;
    if (starts !== 1) $display("FAIL single_start_count: got %0d, expected 1", starts);
    else passed++;
    total++;
    if (busy_low !== 1'b0) $display("FAIL single_busy: busy dropped during transaction, expected held high");
    else passed++;
    num_ok = (div_numerator === 64'd100) && (div_denominator === 32'd7);
    total++;
    if (!num_ok) $display("FAIL single_operands: got %0d/%0d, expected 100/7", div_numerator, div_denominator);
    else passed++;
    total++;
    if (rsp_id !== 2'd2 || rsp_quotient !== 32'd14)
      $display("FAIL single_result: id=%0d q=%0d, expected id=2 q=14", rsp_id, rsp_quotient);
    else passed++;
    total++;
    if (rsp_div_zero !== 1'b0 || rsp_timeout !== 1'b0)
      $display("FAIL single_flags: dz=%b to=%b, expected 0 0", rsp_div_zero, rsp_timeout);
    else passed++;
    release_rsp;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_div_zero !== 1'b0 || rsp_timeout !== 1'b0)
      $display("FAIL single_after_handshake: vld=%b busy=%b dz=%b to=%b, expected all 0",
               rsp_valid, busy, rsp_div_zero, rsp_timeout);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int order[$];
    bit multi;
    int got;
    apply_reset;
    model_lat = 3;
    rsp_ready = 1'b1;
    multi     = 1'b0;
    tick;
    for (int i = 0; i < N; i++) set_req(i, 64'(1000 * (i + 1)), 32'(i + 3));
    req_valid = 4'hF;
    for (int c = 0; c < 400 && order.size() < 8; c++) begin
      @(negedge clk);
      if ($countones(req_ready) > 1) multi = 1'b1;
      for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
    end
    tick;
    req_valid = '0;
    wait_idle("back_to_back");
    rsp_ready = 1'b0;
    total++;
    if (multi) $display("FAIL b2b_onehot: req_ready was multi-hot, expected one-hot or zero");
    else passed++;
    for (int k = 0; k < 8; k++) begin
      got = (k < order.size()) ? order[k] : -1;
      total++;
      if (got !== k % N) $display("FAIL b2b_grant_%0d: got %0d, expected %0d", k, got, k % N);
      else passed++;
    end
  endtask

  task automatic test_div_zero;
    logic [N-1:0] rdy;
    int lat, starts;
    bit busy_low;
    rsp_ready = 1'b0;
    drive_txn(1, 64'd55, 32'd0, rdy, lat, starts, busy_low);
    total++;
    if (rdy !== 4'b0010) $display("FAIL dz_ready: got %b, expected 0010", rdy);
    else passed++;
    total++;
    if (lat !== 1 || starts !== 0)
      $display("FAIL dz_timing: latency=%0d starts=%0d, expected 1 and 0", lat, starts);
    else passed++;
    total++;
    if (rsp_id !== 2'd1 || rsp_quotient !== 32'hFFFF_FFFF || rsp_div_zero !== 1'b1 || rsp_timeout !== 1'b0)
      $display("FAIL dz_result: id=%0d q=%h dz=%b to=%b, expected 1 ffffffff 1 0",
               rsp_id, rsp_quotient, rsp_div_zero, rsp_timeout);
    else passed++;
    release_rsp;
    wait_idle("div_zero");
  endtask

  task automatic test_timeout;
    logic [N-1:0] rdy;
    int lat, starts;
    bit busy_low;
    model_hang = 1'b1;
    rsp_ready  = 1'b0;
    drive_txn(0, 64'd9, 32'd3, rdy, lat, starts, busy_low);
    total++;
    if (lat !== 66 || starts !== 1)
      $display("FAIL to_latency: latency=%0d starts=%0d, expected 66 and 1", lat, starts);
    else passed++;
    total++;
    if (rsp_id !== 2'd0 || rsp_quotient !== 32'd0 || rsp_timeout !== 1'b1 || rsp_div_zero !== 1'b0)
      $display("FAIL to_result: id=%0d q=%h to=%b dz=%b, expected 0 0 1 0",
               rsp_id, rsp_quotient, rsp_timeout, rsp_div_zero);
    else passed++;
    release_rsp;
    model_hang = 1'b0;
    model_lat  = 5;
    drive_txn(3, 64'd1000, 32'd10, rdy, lat, starts, busy_low);
    total++;
    if (rdy !== 4'b1000 || lat !== 7)
      $display("FAIL to_followup_timing: ready=%b latency=%0d, expected 1000 and 7", rdy, lat);
    else passed++;
    total++;
    if (rsp_id !== 2'd3 || rsp_quotient !== 32'd100 || rsp_timeout !== 1'b0 || rsp_div_zero !== 1'b0)
      $display("FAIL to_followup_result: id=%0d q=%0d to=%b dz=%b, expected 3 100 0 0",
               rsp_id, rsp_quotient, rsp_timeout, rsp_div_zero);
    else passed++;
    release_rsp;
    wait_idle("timeout");
  endtask

  task automatic test_backpressure;
    logic [N-1:0] rdy;
    int lat, starts, n;
    bit busy_low, stable, no_ready;
    model_lat = 2;
    rsp_ready = 1'b0;
    drive_txn(2, 64'd77, 32'd7, rdy, lat, starts, busy_low);
    total++;
    if (lat !== 4) $display("FAIL bp_latency: got %0d, expected 4", lat);
    else passed++;
    tick;
    set_req(0, 64'd50, 32'd5);
    req_valid = 4'b0001;
    stable    = 1'b1;
    no_ready  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_quotient !== 32'd11 ||
          rsp_div_zero !== 1'b0 || rsp_timeout !== 1'b0) stable = 1'b0;
      if (req_ready !== '0) no_ready = 1'b0;
    end
    total++;
    if (!stable) $display("FAIL bp_stable: response changed while stalled (id=%0d q=%0d), expected id=2 q=11 held", rsp_id, rsp_quotient);
    else passed++;
    total++;
    if (!no_ready) $display("FAIL bp_no_ready: req_ready asserted while stalled, expected 0");
    else passed++;
    release_rsp;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001 || busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL bp_next_grant: ready=%b busy=%b vld=%b, expected 0001 0 0", req_ready, busy, rsp_valid);
    else passed++;
    tick;
    req_valid = '0;
    wait_rsp(n);
    total++;
    if (n < 0 || rsp_id !== 2'd0 || rsp_quotient !== 32'd10)
      $display("FAIL bp_second_result: wait=%0d id=%0d q=%0d, expected id=0 q=10", n, rsp_id, rsp_quotient);
    else passed++;
    release_rsp;
    wait_idle("backpressure");
  endtask

  task automatic test_reset_mid_wait;
    bit bad;
    int n;
    model_lat = 30;
    rsp_ready = 1'b0;
    tick;
    set_req(1, 64'd40, 32'd4);
    req_valid = 4'b0010;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010) $display("FAIL rst_grant: got %b, expected 0010", req_ready);
    else passed++;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    tick;
    rstn = 1'b0;
    tick;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_div_zero, rsp_timeout,
         div_start, div_numerator, div_denominator, busy} !== '0)
      $display("FAIL rst_mid_outputs: vld=%b st=%b num=%h den=%h busy=%b, expected all 0",
               rsp_valid, div_start, div_numerator, div_denominator, busy);
    else passed++;
    tick;
    rstn = 1'b1;
    bad  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL rst_late_done: DUT reacted to a stale div_done, expected to stay idle");
    else passed++;
    tick;
    set_req(0, 64'd9, 32'd3);
    set_req(3, 64'd8, 32'd2);
    req_valid = 4'b1001;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) $display("FAIL rst_rr_ptr: got %b, expected 0001", req_ready);
    else passed++;
    tick;
    req_valid = '0;
    model_lat = 3;
    wait_rsp(n);
    total++;
    if (n < 0 || rsp_id !== 2'd0 || rsp_quotient !== 32'd3)
      $display("FAIL rst_after_result: wait=%0d id=%0d q=%0d, expected id=0 q=3", n, rsp_id, rsp_quotient);
    else passed++;
    release_rsp;
    wait_idle("reset_mid_wait");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req_valid       = '0;
    req_numerator   = '0;
    req_denominator = '0;
    rsp_ready       = 1'b0;
    rstn            = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_div_zero;
    test_timeout;
    test_backpressure;
    test_reset_mid_wait;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
